// File: rtl/multilevel_pwm_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : multilevel_pwm_gen_if
// Summary  : Control and gate-output bundle between the modulation controller
//            and the multilevel PWM generator.
// Revision : 1.0 - initial release
// ============================================================================
interface multilevel_pwm_gen_if #(
    parameter int LEVEL_COUNT = 4,
    parameter int WIDTH       = 16,
    parameter int CMP_WIDTH   = WIDTH + $clog2(LEVEL_COUNT + 1),
    parameter int DT_WIDTH    = 8
);
    logic                     Enable;
    logic [CMP_WIDTH-1:0]     Compare;
    logic [WIDTH-1:0]         PWMMaxCount;
    logic [WIDTH-1:0]         TriangleStepSize;
    logic [DT_WIDTH-1:0]      DeadTimeCount;
    logic [2*LEVEL_COUNT-1:0] S;
    logic                     CarrierValley;
    logic [WIDTH-1:0]         Carrier;

    // Controller side: drives the reference and carrier setup, observes gates.
    modport master (
        output Enable,
        output Compare,
        output PWMMaxCount,
        output TriangleStepSize,
        output DeadTimeCount,
        input  S,
        input  CarrierValley,
        input  Carrier
    );

    // Generator side.
    modport slave (
        input  Enable,
        input  Compare,
        input  PWMMaxCount,
        input  TriangleStepSize,
        input  DeadTimeCount,
        output S,
        output CarrierValley,
        output Carrier
    );
endinterface
`default_nettype wire

// File: rtl/multilevel_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : multilevel_pwm_gen
// Summary  : N-level PWM from one shared triangle carrier with level-shifted
//            bands, valley-aligned shadow loading and per-level dead time.
// Revision : 1.0 - initial release
// ============================================================================
module multilevel_pwm_gen #(
    parameter int LEVEL_COUNT = 4,
    parameter int WIDTH       = 16,
    parameter int CMP_WIDTH   = WIDTH + $clog2(LEVEL_COUNT + 1),
    parameter int DT_WIDTH    = 8
) (
    input  logic                MClk,
    input  logic                RstN,
    multilevel_pwm_gen_if.slave pwm
);

    localparam int CW1 = CMP_WIDTH + 1;

    typedef enum logic [0:0] {
        DT_IDLE = 1'b0,
        DT_DEAD = 1'b1
    } dt_state_e;

    // Active (shadow) copies of the setup inputs
    logic [CMP_WIDTH-1:0]   compare_q, compare_d;
    logic [WIDTH-1:0]       max_q, max_d;
    logic [WIDTH-1:0]       step_q, step_d;
    logic [DT_WIDTH-1:0]    dt_q, dt_d;

    // Carrier state
    logic [WIDTH-1:0]       carrier_q, carrier_d;
    logic                   dir_down_q, dir_down_d;
    logic                   valley_q, valley_d;
    logic [WIDTH:0]         up_sum;

    // Raw per-level compare results
    logic [LEVEL_COUNT-1:0] raw_q, raw_d;

    // ------------------------------------------------------------------------
    // Triangle carrier. The extra sum bit keeps Carrier+Step from wrapping.
    // ------------------------------------------------------------------------
    always_comb begin
        up_sum     = {1'b0, carrier_q} + {1'b0, step_q};
        carrier_d  = carrier_q;
        dir_down_d = dir_down_q;
        valley_d   = 1'b0;

        if (!pwm.Enable || (max_q == '0)) begin
            carrier_d  = '0;
            dir_down_d = 1'b0;
        end else if (!dir_down_q) begin
            if (up_sum >= {1'b0, max_q}) begin
                carrier_d  = max_q;
                dir_down_d = 1'b1;
            end else begin
                carrier_d  = up_sum[WIDTH-1:0];
            end
        end else if (carrier_q <= step_q) begin
            carrier_d  = '0;
            dir_down_d = 1'b0;
            valley_d   = 1'b1;
        end else begin
            carrier_d  = carrier_q - step_q;
        end
    end

    // Shadows update on the same edge that raises CarrierValley, so the new
    // period starts at Carrier=0 with a consistent parameter set.
    always_comb begin
        compare_d = compare_q;
        max_d     = max_q;
        step_d    = step_q;
        dt_d      = dt_q;
        if (!pwm.Enable || valley_d) begin
            compare_d = pwm.Compare;
            max_d     = pwm.PWMMaxCount;
            step_d    = pwm.TriangleStepSize;
            dt_d      = pwm.DeadTimeCount;
        end
    end

    // ------------------------------------------------------------------------
    // Level k owns the band k*Max .. (k+1)*Max; a zero peak disables all bands.
    // ------------------------------------------------------------------------
    always_comb begin
        raw_d = '0;
        for (int k = 0; k < LEVEL_COUNT; k++) begin
            if (max_q != '0) begin
                raw_d[k] = ({1'b0, compare_q} >
                            (CW1'(k) * CW1'(max_q) + CW1'(carrier_q)));
            end
        end
    end

    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            compare_q  <= '0;
            max_q      <= '0;
            step_q     <= '0;
            dt_q       <= '0;
            carrier_q  <= '0;
            dir_down_q <= 1'b0;
            valley_q   <= 1'b0;
            raw_q      <= '0;
        end else begin
            compare_q  <= compare_d;
            max_q      <= max_d;
            step_q     <= step_d;
            dt_q       <= dt_d;
            carrier_q  <= carrier_d;
            dir_down_q <= dir_down_d;
            valley_q   <= valley_d;
            raw_q      <= raw_d;
        end
    end

    assign pwm.Carrier       = carrier_q;
    assign pwm.CarrierValley = valley_q;

    // ------------------------------------------------------------------------
    // Per-level dead-time insertion. The pair is only ever {R,~R} or 00, so
    // both switches of a leg can never be on together.
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < LEVEL_COUNT; k++) begin : g_level
            dt_state_e           state_q;
            logic [DT_WIDTH-1:0] cnt_q;
            logic                r_last_q;
            logic                s_hi_q;
            logic                s_lo_q;
            logic                r_now;
            logic                r_changed;

            assign r_now     = raw_q[k];
            assign r_changed = r_now ^ r_last_q;

            always_ff @(posedge MClk or negedge RstN) begin
                if (!RstN) begin
                    state_q  <= DT_IDLE;
                    cnt_q    <= '0;
                    r_last_q <= 1'b0;
                    s_hi_q   <= 1'b0;
                    s_lo_q   <= 1'b0;
                end else if (!pwm.Enable) begin
                    // Track R while parked so re-enabling does not see a stale edge.
                    state_q  <= DT_IDLE;
                    cnt_q    <= '0;
                    r_last_q <= r_now;
                    s_hi_q   <= 1'b0;
                    s_lo_q   <= 1'b0;
                end else begin
                    r_last_q <= r_now;
                    case (state_q)
                        DT_IDLE: begin
                            if (r_changed && (dt_q != '0)) begin
                                state_q <= DT_DEAD;
                                cnt_q   <= dt_q - DT_WIDTH'(1);
                                s_hi_q  <= 1'b0;
                                s_lo_q  <= 1'b0;
                            end else begin
                                s_hi_q  <= r_now;
                                s_lo_q  <= ~r_now;
                            end
                        end
                        DT_DEAD: begin
                            if (r_changed && (dt_q != '0)) begin
                                cnt_q   <= dt_q - DT_WIDTH'(1);
                            end else if (r_changed || (cnt_q == '0)) begin
                                state_q <= DT_IDLE;
                                cnt_q   <= '0;
                                s_hi_q  <= r_now;
                                s_lo_q  <= ~r_now;
                            end else begin
                                cnt_q   <= cnt_q - DT_WIDTH'(1);
                            end
                        end
                        default: begin
                            state_q <= DT_IDLE;
                            cnt_q   <= '0;
                            s_hi_q  <= 1'b0;
                            s_lo_q  <= 1'b0;
                        end
                    endcase
                end
            end

            assign pwm.S[2*k]   = s_hi_q;
            assign pwm.S[2*k+1] = s_lo_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multilevel_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_multilevel_pwm_gen
// Summary  : Scoreboard bench for multilevel_pwm_gen with randomised setups.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multilevel_pwm_gen;

    localparam int L     = 3;
    localparam int W     = 10;
    localparam int CW    = W + $clog2(L + 1);
    localparam int DW    = 6;
    localparam int NEVER = -1000000;

    typedef struct {
        logic [2*L-1:0] s;
        logic [W-1:0]   carrier;
        logic           valley;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];

    // Reference model state
    int             m_car, m_max, m_step, m_dt, m_cmp, n;
    bit             m_down, m_valley;
    bit             m_r[L];
    bit             m_r_prev[L];
    int             t_last[L];
    int             dt_at[L];
    logic [2*L-1:0] m_s;

    multilevel_pwm_gen_if #(
        .LEVEL_COUNT(L), .WIDTH(W), .CMP_WIDTH(CW), .DT_WIDTH(DW)
    ) bus ();

    multilevel_pwm_gen #(
        .LEVEL_COUNT(L), .WIDTH(W), .CMP_WIDTH(CW), .DT_WIDTH(DW)
    ) dut (
        .MClk (clk),
        .RstN (rst_n),
        .pwm  (bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_car = 0; m_max = 0; m_step = 0; m_dt = 0; m_cmp = 0;
        m_down = 1'b0; m_valley = 1'b0; m_s = '0;
        for (int k = 0; k < L; k++) begin
            m_r[k] = 1'b0; m_r_prev[k] = 1'b0; t_last[k] = NEVER; dt_at[k] = 0;
        end
    endtask

    // Gate pair of level k is 00 while its latest R edge is younger than the
    // dead time captured at that edge; otherwise it shows the previous R.
    task automatic model_step();
        int nc;
        bit nd, nv, en;
        bit nr[L];
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        en = (bus.Enable === 1'b1);
        nc = m_car; nd = m_down; nv = 1'b0;
        if (!en || m_max == 0) begin
            nc = 0; nd = 1'b0;
        end else if (!m_down) begin
            if (m_car + m_step >= m_max) begin nc = m_max; nd = 1'b1; end
            else nc = m_car + m_step;
        end else if (m_car <= m_step) begin
            nc = 0; nd = 1'b0; nv = 1'b1;
        end else begin
            nc = m_car - m_step;
        end
        for (int k = 0; k < L; k++) begin
            nr[k] = (m_max != 0) && (m_cmp > k * m_max + m_car);
            if (!en) t_last[k] = NEVER;
            else if (m_r[k] != m_r_prev[k]) begin t_last[k] = n; dt_at[k] = m_dt; end
            if (en && !(dt_at[k] > 0 && (n + 1 - t_last[k]) <= dt_at[k])) begin
                m_s[2*k] = m_r[k]; m_s[2*k+1] = !m_r[k];
            end else begin
                m_s[2*k] = 1'b0; m_s[2*k+1] = 1'b0;
            end
        end
        if (!en || nv) begin
            m_cmp = int'(bus.Compare); m_max = int'(bus.PWMMaxCount);
            m_step = int'(bus.TriangleStepSize); m_dt = int'(bus.DeadTimeCount);
        end
        for (int k = 0; k < L; k++) begin
            m_r_prev[k] = m_r[k]; m_r[k] = nr[k];
        end
        m_car = nc; m_down = nd; m_valley = nv;
        n++;
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        e.s = m_s; e.carrier = W'(m_car); e.valley = m_valley;
        sb.push_back(e);
        #2;
    endtask

    task automatic set_in(input int cmp, input int mx, input int st, input int dt);
        bus.Compare = CW'(cmp); bus.PWMMaxCount = W'(mx);
        bus.TriangleStepSize = W'(st); bus.DeadTimeCount = DW'(dt);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // Monitor: clock negedge pops the scoreboard; a reset edge while clk is
    // high checks the asynchronous clear.
    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        if (clk === 1'b1) begin
            #1;
            checks++;
            if (bus.S !== '0 || bus.Carrier !== '0 || bus.CarrierValley !== 1'b0) begin
                failures++;
                $display("FAIL async_reset S=%b Carrier=%0d Valley=%b required all zero",
                         bus.S, bus.Carrier, bus.CarrierValley);
            end
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            cyc++;
            checks++;
            if (bus.S !== e.s) begin
                failures++;
                $display("FAIL gates cyc=%0d got=%b exp=%b", cyc, bus.S, e.s);
            end
            checks++;
            if (bus.Carrier !== e.carrier) begin
                failures++;
                $display("FAIL carrier cyc=%0d got=%0d exp=%0d", cyc, bus.Carrier, e.carrier);
            end
            checks++;
            if (bus.CarrierValley !== e.valley) begin
                failures++;
                $display("FAIL valley cyc=%0d got=%b exp=%b", cyc, bus.CarrierValley, e.valley);
            end
            for (int k = 0; k < L; k++) begin
                checks++;
                if (bus.S[2*k] === 1'b1 && bus.S[2*k+1] === 1'b1) begin
                    failures++;
                    $display("FAIL overlap cyc=%0d level=%0d got=11 exp=not 11", cyc, k);
                end
            end
        end
    end

    initial begin
        int mx, st, dt, cmp, sel;
        bit prev_degen;
        rst_n = 1'b0;
        bus.Enable = 1'b0;
        set_in(0, 0, 0, 0);
        n = 0;
        model_reset();
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Level 0 saturated, level 1 partial, level 2 off
        set_in(150, 100, 2, 5);
        repeat (2) tick();
        bus.Enable = 1'b1;
        repeat (420) tick();
        // Mid-slope change into the top band; takes effect at the next valley
        bus.Compare = CW'(250);
        repeat (437) tick();
        // Saturation both ways and above full scale
        bus.Compare = CW'(0);   repeat (300) tick();
        bus.Compare = CW'(300); repeat (300) tick();
        bus.Compare = CW'(330); repeat (150) tick();
        // No dead time
        set_in(130, 100, 2, 0); repeat (320) tick();
        // Compare just below the peak: R toggles twice within a few cycles
        set_in(39, 20, 2, 5);   repeat (300) tick();
        set_in(19, 20, 3, 5);   repeat (200) tick();
        // Enable low for 10 cycles, then restart from the valley
        bus.Enable = 1'b0; set_in(110, 60, 3, 4);
        repeat (10) tick();
        bus.Enable = 1'b1;
        repeat (250) tick();
        // Asynchronous reset mid-period; shadows come back as zero
        repeat (57) tick();
        async_reset();
        repeat (20) tick();
        bus.Enable = 1'b0; repeat (2) tick();
        bus.Enable = 1'b1; repeat (200) tick();
        // Frozen carrier with zero step, then zero peak
        bus.Enable = 1'b0; set_in(50, 40, 0, 3); repeat (2) tick();
        bus.Enable = 1'b1; repeat (60) tick();
        bus.Enable = 1'b0; set_in(50, 0, 4, 3); repeat (2) tick();
        bus.Enable = 1'b1; repeat (60) tick();

        prev_degen = 1'b1;
        for (int seg = 0; seg < 25; seg++) begin
            mx  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(4, 120));
            st  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9));
            dt  = int'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       cmp = 0;
                1:       cmp = L * mx;
                2:       cmp = L * mx + int'($urandom_range(0, 50));
                default: cmp = int'($urandom_range(0, L * mx));
            endcase
            set_in(cmp, mx, st, dt);
            if (prev_degen || $urandom_range(0, 2) == 0) begin
                bus.Enable = 1'b0;
                repeat ($urandom_range(1, 12)) tick();
            end
            bus.Enable = 1'b1;
            repeat ($urandom_range(150, 500)) begin
                if ($urandom_range(0, 40) == 0)
                    bus.Compare = CW'($urandom_range(0, L * mx + 20));
                if ($urandom_range(0, 200) == 0)
                    bus.DeadTimeCount = DW'($urandom_range(0, 7));
                tick();
            end
            prev_degen = (mx == 0) || (st == 0);
            if ($urandom_range(0, 4) == 0) begin
                async_reset();
                prev_degen = 1'b1;
            end
        end

        repeat (2) tick();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
